// File: rtl/uart_cmd_pkg.sv
// Shared types and limits for the UART command-frame parser.
package uart_cmd_pkg;

   localparam int         LEN_W             = 4;
   localparam int         MAX_PAYLOAD_LIMIT = 15;
   localparam logic [7:0] SOF_DEFAULT       = 8'hA5;

   typedef enum logic [2:0] {
      ST_HUNT,
      ST_CMD,
      ST_LEN,
      ST_PAYLOAD,
      ST_CHK,
      ST_HOLD
   } state_e;

endpackage

// File: rtl/uart_cmd_timer.sv
// Inter-byte timeout counter; expire_o is high on the terminal baud tick
// unless a byte arrives in that same cycle.
module uart_cmd_timer #(
   parameter int TIMEOUT_TICKS = 32
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick_i,
   input  logic active_i,
   input  logic clear_i,
   output logic expire_o
);

   localparam int CNT_W = $clog2(TIMEOUT_TICKS + 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign expire_o = active_i && !clear_i && tick_i &&
                     (cnt_q == CNT_W'(TIMEOUT_TICKS - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (!active_i || clear_i || expire_o) begin
         cnt_d = '0;
      end else if (tick_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_cmd_parser.sv
// Frame parser: SOF, CMD, LEN, payload, XOR checksum -> valid/ready command.
// Optional inter-byte timeout is enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_parser
   import uart_cmd_pkg::*;
#(
   parameter int         MAX_PAYLOAD   = 8,
   parameter logic [7:0] SOF_BYTE      = SOF_DEFAULT,
   parameter int         TIMEOUT_TICKS = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     baud_clk_en,
   input  logic [7:0]               byte_in,
   input  logic                     byte_valid,
   output logic                     cmd_valid,
   input  logic                     cmd_ready,
   output logic [7:0]               cmd_code,
   output logic [LEN_W-1:0]         cmd_len,
   output logic [8*MAX_PAYLOAD-1:0] cmd_payload,
   output logic                     chk_err,
   output logic                     len_err,
   output logic                     overrun,
   output logic                     timeout_err
);

   state_e           state_q;
   logic [7:0]       code_q;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] idx_q;
   logic [LEN_W-1:0] idx_d;
   logic [7:0]       chk_q;
   logic [7:0]       chk_d;
   logic             cmd_valid_q;
   logic             chk_err_q;
   logic             len_err_q;
   logic             overrun_q;
   logic             timeout_err_q;
   logic             timeout_hit;
   logic             sof_accept;
   logic             pay_wr;

   assign idx_d      = idx_q + LEN_W'(1);
   assign chk_d      = chk_q ^ byte_in;
   assign sof_accept = (state_q == ST_HUNT) && byte_valid && (byte_in == SOF_BYTE);
   assign pay_wr     = (state_q == ST_PAYLOAD) && byte_valid;

`ifdef UART_CMD_TIMEOUT_EN
   logic timer_active;
   assign timer_active = (state_q == ST_CMD) || (state_q == ST_LEN) ||
                         (state_q == ST_PAYLOAD) || (state_q == ST_CHK);

   uart_cmd_timer #(
      .TIMEOUT_TICKS(TIMEOUT_TICKS)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick_i   (baud_clk_en),
      .active_i (timer_active),
      .clear_i  (byte_valid),
      .expire_o (timeout_hit)
   );
   assign timeout_err = timeout_err_q;
`else
   logic unused_timeout;
   assign timeout_hit    = 1'b0;
   assign timeout_err    = 1'b0;
   assign unused_timeout = &{1'b0, baud_clk_en, timeout_err_q, TIMEOUT_TICKS[0]};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_HUNT;
         code_q        <= '0;
         len_q         <= '0;
         idx_q         <= '0;
         chk_q         <= '0;
         cmd_valid_q   <= 1'b0;
         chk_err_q     <= 1'b0;
         len_err_q     <= 1'b0;
         overrun_q     <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         chk_err_q     <= 1'b0;
         len_err_q     <= 1'b0;
         overrun_q     <= 1'b0;
         timeout_err_q <= 1'b0;
         if (timeout_hit) begin
            state_q       <= ST_HUNT;
            timeout_err_q <= 1'b1;
         end else begin
            case (state_q)
               ST_HUNT: begin
                  if (sof_accept) begin
                     state_q <= ST_CMD;
                     chk_q   <= '0;
                     idx_q   <= '0;
                  end
               end
               ST_CMD: begin
                  if (byte_valid) begin
                     code_q  <= byte_in;
                     chk_q   <= byte_in;
                     state_q <= ST_LEN;
                  end
               end
               ST_LEN: begin
                  // Values above 15 also exceed MAX_PAYLOAD, so one compare covers both checks
                  if (byte_valid) begin
                     if (byte_in > 8'(MAX_PAYLOAD)) begin
                        len_err_q <= 1'b1;
                        state_q   <= ST_HUNT;
                     end else begin
                        len_q   <= byte_in[LEN_W-1:0];
                        chk_q   <= chk_d;
                        state_q <= (byte_in == 8'h00) ? ST_CHK : ST_PAYLOAD;
                     end
                  end
               end
               ST_PAYLOAD: begin
                  if (byte_valid) begin
                     chk_q <= chk_d;
                     idx_q <= idx_d;
                     if (idx_d == len_q) begin
                        state_q <= ST_CHK;
                     end
                  end
               end
               ST_CHK: begin
                  if (byte_valid) begin
                     if (byte_in == chk_q) begin
                        state_q     <= ST_HOLD;
                        cmd_valid_q <= 1'b1;
                     end else begin
                        chk_err_q <= 1'b1;
                        state_q   <= ST_HUNT;
                     end
                  end
               end
               ST_HOLD: begin
                  if (byte_valid) begin
                     overrun_q <= 1'b1;
                  end
                  if (cmd_ready) begin
                     state_q     <= ST_HUNT;
                     cmd_valid_q <= 1'b0;
                  end
               end
               default: state_q <= ST_HUNT;
            endcase
         end
      end
   end

   // Buffer is zeroed on every SOF so bytes beyond cmd_len always read as 0
   genvar gi;
   generate
      for (gi = 0; gi < MAX_PAYLOAD; gi++) begin : g_buf
         logic [7:0] byte_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               byte_q <= '0;
            end else if (sof_accept) begin
               byte_q <= '0;
            end else if (pay_wr && (idx_q == LEN_W'(gi))) begin
               byte_q <= byte_in;
            end
         end
         assign cmd_payload[8*gi +: 8] = byte_q;
      end
   endgenerate

   assign cmd_valid = cmd_valid_q;
   assign cmd_code  = code_q;
   assign cmd_len   = len_q;
   assign chk_err   = chk_err_q;
   assign len_err   = len_err_q;
   assign overrun   = overrun_q;

endmodule
